sap_clock_ctrl: RTL and testbench



---
 rtl/sap_clk_pkg.sv | 12 +
 rtl/edge_rise.sv | 18 +
 rtl/sap_clock_ctrl.sv | 101 ++++++++++
 tb/tb_sap_clock_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sap_clk_pkg.sv
// Shared state encoding for the SAP-1 clock controller.
package sap_clk_pkg;
  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    PAUSED = ST_PAUSED,
    RUN    = ST_RUN,
    HALTED = ST_HALTED
  } clk_state_e;
endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector; RST_VAL=1 keeps a level held through reset from firing.
module edge_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= RST_VAL;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/sap_clock_ctrl.sv
// SAP-1 clock-enable generator: single-step, auto-run divider and HLT latch.
module sap_clock_ctrl
  import sap_clk_pkg::*;
#(
  parameter int unsigned AUTO_DIV  = 25_000_000,
  parameter int unsigned CNT_W     = 25,
  parameter int unsigned STEPCNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_pb,
  input  logic                 run_pb,
  input  logic                 mode_auto,
  input  logic                 hlt,
  output logic                 cpu_clk_en,
  output logic                 clk_led,
  output logic                 halted,
  output logic [1:0]           state_o,
  output logic [STEPCNT_W-1:0] pulse_cnt
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(AUTO_DIV - 1);

  logic mode_s1_q, mode_s_q;
  logic step_rise, run_rise;
  clk_state_e state_q, state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic en_q, led_q, pulse;
  logic [STEPCNT_W-1:0] pcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q <= 1'b0;
      mode_s_q  <= 1'b0;
    end else begin
      mode_s1_q <= mode_auto;
      mode_s_q  <= mode_s1_q;
    end
  end

  edge_rise #(.RST_VAL(1'b1)) u_step_rise (
    .clk(clk), .rst_n(rst_n), .d_i(step_pb), .rise_o(step_rise)
  );
  edge_rise #(.RST_VAL(1'b1)) u_run_rise (
    .clk(clk), .rst_n(rst_n), .d_i(run_pb), .rise_o(run_rise)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    pulse     = 1'b0;
    // hlt overrides every event, including a terminal-count pulse
    if (hlt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        RUN: begin
          if (run_rise || !mode_s_q) begin
            state_d   = PAUSED;
            div_cnt_d = '0;
          end else if (div_cnt_q == TERM) begin
            pulse     = 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        HALTED: state_d = HALTED;
        default: begin
          if (run_rise && mode_s_q) begin
            state_d   = RUN;
            div_cnt_d = '0;
          end else if (step_rise) begin
            pulse = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PAUSED;
      div_cnt_q <= '0;
      en_q      <= 1'b0;
      led_q     <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      en_q      <= pulse;
      led_q     <= led_q ^ pulse;
      pcnt_q    <= pcnt_q + STEPCNT_W'(pulse);
    end
  end

  assign cpu_clk_en = en_q;
  assign clk_led    = led_q;
  assign halted     = (state_q == HALTED);
  assign state_o    = state_q;
  assign pulse_cnt  = pcnt_q;
endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Directed + randomized bench for sap_clock_ctrl against a cycle-level behavioural model.
module tb_sap_clock_ctrl;
  localparam int AUTO_DIV = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic step_pb = 1'b0, run_pb = 1'b0, mode_auto = 1'b0, hlt = 1'b0;
  logic cpu_clk_en, clk_led, halted;
  logic [1:0] state_o;
  logic [7:0] pulse_cnt;

  int checks = 0, failures = 0;

  // behavioural model: state as int, cycles-to-next-pulse countdown, mode sync as a queue
  int m_state, m_left;
  bit m_step_prev, m_run_prev, m_en, m_led;
  bit m_msync[$];
  logic [7:0] m_cnt;
  int en_seen;

  sap_clock_ctrl #(.AUTO_DIV(AUTO_DIV), .CNT_W(3), .STEPCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .step_pb(step_pb), .run_pb(run_pb),
    .mode_auto(mode_auto), .hlt(hlt), .cpu_clk_en(cpu_clk_en),
    .clk_led(clk_led), .halted(halted), .state_o(state_o), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_step_prev = 1; m_run_prev = 1;
    m_en = 0; m_led = 0; m_cnt = 8'd0;
    m_msync = {1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit srise, rrise, ms, p;
    srise = step_pb && !m_step_prev;
    rrise = run_pb && !m_run_prev;
    ms = m_msync.pop_front();
    m_msync.push_back(mode_auto);
    p = 0;
    if (hlt) m_state = 2;
    else if (m_state == 1) begin
      if (rrise || !ms) m_state = 0;
      else begin
        m_left--;
        if (m_left == 0) begin p = 1; m_left = AUTO_DIV; end
      end
    end else if (m_state == 0) begin
      if (rrise && ms) begin m_state = 1; m_left = AUTO_DIV; end
      else if (srise) p = 1;
    end
    m_step_prev = step_pb; m_run_prev = run_pb;
    m_en = p;
    if (p) begin m_led = !m_led; m_cnt++; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"}, {31'b0, cpu_clk_en}, {31'b0, m_en});
    chk({tag, ".led"}, {31'b0, clk_led}, {31'b0, m_led});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_state == 2});
    chk({tag, ".state"}, {30'b0, state_o}, m_state);
    chk({tag, ".cnt"}, {24'b0, pulse_cnt}, {24'b0, m_cnt});
  endtask

  task automatic cyc(input string tag, input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk); #1;
      if (cpu_clk_en) en_seen++;
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    check_all("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic enter_run();
    step_pb = 0; run_pb = 0; mode_auto = 0;
    cyc("prep", 3);
    mode_auto = 1;
    cyc("msync", 3);
    run_pb = 1; cyc("runp");
    run_pb = 0;
  endtask

  initial begin
    // reset with buttons held: no spurious pulse
    step_pb = 1; run_pb = 1;
    #2;
    do_reset();
    en_seen = 0;
    cyc("held", 10);
    chk("held.nopulse", en_seen, 0);

    // manual single step held long
    step_pb = 0; run_pb = 0; cyc("rel", 2);
    en_seen = 0;
    step_pb = 1; cyc("step", 100);
    chk("step.once", en_seen, 1);
    chk("step.cnt", {24'b0, pulse_cnt}, 1);
    chk("step.led", {31'b0, clk_led}, 1);

    // auto run: five pulses spaced AUTO_DIV apart, then pause
    enter_run();
    chk("run.state", {30'b0, state_o}, 1);
    en_seen = 0;
    cyc("run", 3);
    chk("run.nofirst", en_seen, 0);
    cyc("run", 1);
    chk("run.first", {31'b0, cpu_clk_en}, 1);
    cyc("run", 16);
    chk("run.five", en_seen, 5);
    run_pb = 1; cyc("pause"); run_pb = 0;
    chk("pause.state", {30'b0, state_o}, 0);
    en_seen = 0;
    cyc("paused", 12);
    chk("pause.none", en_seen, 0);

    // randomized button/mode activity
    for (int i = 0; i < 400; i++) begin
      step_pb = ($urandom_range(0, 3) == 0);
      run_pb  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) mode_auto = ~mode_auto;
      cyc("rand");
    end

    // mode drop forces pause; step works afterwards
    enter_run();
    cyc("run2", 5);
    mode_auto = 0;
    cyc("drop", 3);
    chk("drop.state", {30'b0, state_o}, 0);
    en_seen = 0;
    step_pb = 1; cyc("drop.step", 5); step_pb = 0; cyc("drop.step", 2);
    chk("drop.once", en_seen, 1);

    // async reset mid-run
    enter_run();
    cyc("run3", 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    en_seen = 0;
    cyc("postrst", 6);
    chk("postrst.none", en_seen, 0);

    // 256 manual steps wrap the counter and return the LED to 0
    mode_auto = 0;
    cyc("wprep", 3);
    for (int i = 0; i < 256; i++) begin
      step_pb = 1; cyc("wrap"); step_pb = 0; cyc("wrap");
    end
    chk("wrap.cnt", {24'b0, pulse_cnt}, 0);
    chk("wrap.led", {31'b0, clk_led}, 0);

    // hlt on the terminal-count cycle suppresses the pulse
    enter_run();
    for (int i = 0; i < 10 && m_left != 1; i++) cyc("tohlt");
    chk("hlt.align", m_left, 1);
    hlt = 1; cyc("hlt"); hlt = 0;
    chk("hlt.nopulse", {31'b0, cpu_clk_en}, 0);
    chk("hlt.halted", {31'b0, halted}, 1);
    chk("hlt.state", {30'b0, state_o}, 2);
    en_seen = 0;
    step_pb = 1; cyc("halt", 3); step_pb = 0; cyc("halt", 2);
    run_pb = 1; cyc("halt", 3); run_pb = 0; cyc("halt", 10);
    chk("halt.none", en_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
